// File: rtl/rv_ex_mdu.sv
// rv_ex_mdu: iterative radix-2 RV32M/RV64M multiply/divide unit with stall handshake and flush
module rv_ex_mdu #(
  parameter int XLEN       = 32,
  parameter int REG_ADDR_W = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start_i,
  input  logic [2:0]            fun3_i,
  input  logic [XLEN-1:0]       op1_i,
  input  logic [XLEN-1:0]       op2_i,
  input  logic [REG_ADDR_W-1:0] waddr_i,
  input  logic                  flush_i,
  output logic                  stall_o,
  output logic                  busy_o,
  output logic                  valid_o,
  output logic                  we_o,
  output logic [REG_ADDR_W-1:0] waddr_o,
  output logic [XLEN-1:0]       result_o
);
  localparam int CW = $clog2(XLEN);
  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
  state_t state, state_n;
  logic [CW-1:0] cnt;
  logic [2:0] fun3;
  logic [REG_ADDR_W-1:0] waddr_q;
  logic [2*XLEN-1:0] acc, acc_n, prod;
  logic [XLEN-1:0] opb, m1_i, m2_i, fast_res, quo, rem, res_n;
  logic [XLEN:0] sum, cand, diff;
  logic s1, s2, s1_i, s2_i, accept, zero_i, ovf_i, fast_i, last;
  always_comb begin
    accept   = state == IDLE && start_i && !flush_i;
    s1_i     = (fun3_i[2] ? !fun3_i[0] : fun3_i[1:0] != 2'b11) && op1_i[XLEN-1];
    s2_i     = (fun3_i[2] ? !fun3_i[0] : fun3_i[1:0] == 2'b01) && op2_i[XLEN-1];
    m1_i     = s1_i ? -op1_i : op1_i;
    m2_i     = s2_i ? -op2_i : op2_i;
    zero_i   = op2_i == '0;
    ovf_i    = fun3_i[2] && !fun3_i[0] && op1_i == {1'b1, {(XLEN-1){1'b0}}} && &op2_i;
    fast_i   = fun3_i[2] && (zero_i || ovf_i);
    fast_res = zero_i ? (fun3_i[1] ? op1_i : '1) : (fun3_i[1] ? '0 : op1_i);
    // multiply: hi half accumulates, lo half shifts out the multiplier
    sum      = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, opb} : '0);
    // divide: hi half is the partial remainder, lo half shifts dividend out and quotient in
    cand     = acc[2*XLEN-1:XLEN-1];
    diff     = cand - {1'b0, opb};
    acc_n    = fun3[2] ? (diff[XLEN] ? {cand[XLEN-1:0], acc[XLEN-2:0], 1'b0}
                                     : {diff[XLEN-1:0], acc[XLEN-2:0], 1'b1})
                       : {sum, acc[XLEN-1:1]};
    prod     = (s1 ^ s2) ? -acc_n : acc_n;
    quo      = (s1 ^ s2) ? -acc_n[XLEN-1:0] : acc_n[XLEN-1:0];
    rem      = s1 ? -acc_n[2*XLEN-1:XLEN] : acc_n[2*XLEN-1:XLEN];
    res_n    = fun3[2] ? (fun3[1] ? rem : quo)
                       : (fun3 == 3'b000 ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN]);
    last     = cnt == CW'(XLEN-1);
    state_n  = state;
    case (state)
      IDLE:    state_n = accept ? (fast_i ? DONE : CALC) : IDLE;
      CALC:    state_n = flush_i ? IDLE : (last ? DONE : CALC);
      default: state_n = IDLE;
    endcase
    stall_o  = accept || state == CALC;
    busy_o   = state != IDLE;
    valid_o  = state == DONE && !flush_i;
    we_o     = valid_o;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      fun3     <= '0;
      waddr_q  <= '0;
      acc      <= '0;
      opb      <= '0;
      s1       <= 1'b0;
      s2       <= 1'b0;
      result_o <= '0;
      waddr_o  <= '0;
    end else begin
      state <= state_n;
      if (accept) begin
        cnt     <= '0;
        fun3    <= fun3_i;
        waddr_q <= waddr_i;
        s1      <= s1_i;
        s2      <= s2_i;
        acc     <= {{XLEN{1'b0}}, fun3_i[2] ? m1_i : m2_i};
        opb     <= fun3_i[2] ? m2_i : m1_i;
        if (fast_i) begin
          result_o <= fast_res;
          waddr_o  <= waddr_i;
        end
      end else if (state == CALC && !flush_i) begin
        acc <= acc_n;
        cnt <= cnt + 1'b1;
        if (last) begin
          result_o <= res_n;
          waddr_o  <= waddr_q;
        end
      end
    end
  end
endmodule

// File: tb/tb_rv_ex_mdu.sv
// tb_rv_ex_mdu: directed checks of rv_ex_mdu at XLEN=32, plus a model-checked XLEN=64 instance
module tb_rv_ex_mdu;
  logic clk = 0, rst = 1;
  logic start_i = 0, flush_i = 0;
  logic [2:0] fun3_i = 0;
  logic [31:0] op1_i = 0, op2_i = 0, result_o;
  logic [4:0] waddr_i = 0, waddr_o;
  logic stall_o, busy_o, valid_o, we_o;
  logic start64 = 0;
  logic [2:0] f64 = 0;
  logic [63:0] a64 = 0, b64 = 0, res64;
  logic [4:0] wa64;
  logic stall64, busy64, valid64, we64;
  int total = 0, bad = 0;

  rv_ex_mdu #(.XLEN(32), .REG_ADDR_W(5)) dut (
    .clk(clk), .rst(rst), .start_i(start_i), .fun3_i(fun3_i), .op1_i(op1_i), .op2_i(op2_i),
    .waddr_i(waddr_i), .flush_i(flush_i), .stall_o(stall_o), .busy_o(busy_o), .valid_o(valid_o),
    .we_o(we_o), .waddr_o(waddr_o), .result_o(result_o));

  rv_ex_mdu #(.XLEN(64), .REG_ADDR_W(5)) dut64 (
    .clk(clk), .rst(rst), .start_i(start64), .fun3_i(f64), .op1_i(a64), .op2_i(b64),
    .waddr_i(5'd17), .flush_i(1'b0), .stall_o(stall64), .busy_o(busy64), .valid_o(valid64),
    .we_o(we64), .waddr_o(wa64), .result_o(res64));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic run(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                     input logic [4:0] wa, input logic [31:0] exp, input int exp_st, input bit hold);
    int n = 0;
    @(negedge clk);
    start_i = 1; fun3_i = f; op1_i = a; op2_i = b; waddr_i = wa;
    #1;
    while (stall_o && n < 200) begin
      n++;
      @(negedge clk);
      if (!hold) start_i = 0;
      #1;
    end
    chk("stalls", 64'(n), 64'(exp_st));
    chk("valid", {63'd0, valid_o}, 64'd1);
    chk("we", {63'd0, we_o}, 64'd1);
    chk("result", {32'd0, result_o}, {32'd0, exp});
    chk("waddr", {59'd0, waddr_o}, {59'd0, wa});
    @(negedge clk);
    start_i = 0;
    #1;
    chk("pulse", {63'd0, valid_o}, 64'd0);
    chk("idle", {63'd0, busy_o}, 64'd0);
  endtask

  function automatic logic [63:0] ref64(input logic [2:0] f, input logic [63:0] a, input logic [63:0] b);
    logic [127:0] sa = {{64{a[63]}}, a}, sb = {{64{b[63]}}, b}, za = {64'd0, a}, zb = {64'd0, b}, p;
    logic signed [63:0] ia = a, ib = b;
    logic ovf = a == 64'h8000_0000_0000_0000 && b == '1;
    case (f)
      3'd0: begin p = za * zb; return p[63:0]; end
      3'd1: begin p = sa * sb; return p[127:64]; end
      3'd2: begin p = sa * zb; return p[127:64]; end
      3'd3: begin p = za * zb; return p[127:64]; end
      3'd4: return b == 0 ? '1 : ovf ? a : 64'(ia / ib);
      3'd5: return b == 0 ? '1 : a / b;
      3'd6: return b == 0 ? a : ovf ? 64'd0 : 64'(ia % ib);
      default: return b == 0 ? a : a % b;
    endcase
  endfunction

  task automatic run64(input logic [2:0] f, input logic [63:0] a, input logic [63:0] b);
    int n = 0;
    @(negedge clk);
    start64 = 1; f64 = f; a64 = a; b64 = b;
    @(negedge clk);
    start64 = 0;
    while (!valid64 && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("valid64", {63'd0, valid64}, 64'd1);
    chk("result64", res64, ref64(f, a, b));
    @(negedge clk);
  endtask

  initial begin
    int vcount;
    #1;
    chk("rst_result", {32'd0, result_o}, 64'd0);
    chk("rst_flags", {60'd0, stall_o, busy_o, valid_o, we_o}, 64'd0);
    chk("rst_waddr", {59'd0, waddr_o}, 64'd0);
    @(negedge clk);
    rst = 0;
    run(3'b000, 32'd7, 32'hFFFF_FFFD, 5'd3, 32'hFFFF_FFEB, 33, 0);
    run(3'b001, 32'h8000_0000, 32'h8000_0000, 5'd4, 32'h4000_0000, 33, 0);
    run(3'b011, 32'h8000_0000, 32'h8000_0000, 5'd5, 32'h4000_0000, 33, 0);
    run(3'b010, 32'h8000_0000, 32'h8000_0000, 5'd6, 32'hC000_0000, 33, 0);
    run(3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd7, 32'hFFFF_FFFF, 33, 0);
    run(3'b100, 32'hFFFF_FFF9, 32'd2, 5'd8, 32'hFFFF_FFFD, 33, 0);
    run(3'b110, 32'hFFFF_FFF9, 32'd2, 5'd9, 32'hFFFF_FFFF, 33, 0);
    run(3'b101, 32'hFFFF_FFF9, 32'd2, 5'd10, 32'h7FFF_FFFC, 33, 0);
    run(3'b111, 32'hFFFF_FFF9, 32'd2, 5'd11, 32'd1, 33, 0);
    run(3'b100, 32'd9, 32'd0, 5'd12, 32'hFFFF_FFFF, 1, 0);
    run(3'b111, 32'd5, 32'd0, 5'd13, 32'd5, 1, 0);
    run(3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 5'd14, 32'h8000_0000, 1, 0);
    run(3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 5'd15, 32'd0, 1, 0);
    run(3'b000, 32'd6, 32'd7, 5'd16, 32'd42, 33, 1);
    run(3'b100, 32'd100, 32'hFFFF_FFF9, 5'd18, 32'hFFFF_FFF2, 33, 1);
    // flush in the tenth CALC cycle
    @(negedge clk);
    start_i = 1; fun3_i = 3'b000; op1_i = 32'd5; op2_i = 32'd6; waddr_i = 5'd20;
    @(negedge clk);
    start_i = 0;
    repeat (9) @(negedge clk);
    flush_i = 1;
    #1;
    chk("flush_valid", {63'd0, valid_o}, 64'd0);
    @(negedge clk);
    flush_i = 0;
    #1;
    chk("flush_idle", {63'd0, busy_o}, 64'd0);
    chk("flush_hold", {32'd0, result_o}, 64'hFFFF_FFF2);
    chk("flush_waddr", {59'd0, waddr_o}, 64'd18);
    vcount = 0;
    repeat (40) begin @(negedge clk); vcount += int'(valid_o); end
    chk("flush_novalid", 64'(vcount), 64'd0);
    run(3'b000, 32'd3, 32'd4, 5'd21, 32'd12, 33, 0);
    // asynchronous reset between edges
    @(negedge clk);
    start_i = 1; fun3_i = 3'b000; op1_i = 32'd3; op2_i = 32'd5; waddr_i = 5'd22;
    @(negedge clk);
    start_i = 0;
    repeat (5) @(negedge clk);
    #2 rst = 1;
    #1;
    chk("arst_result", {32'd0, result_o}, 64'd0);
    chk("arst_waddr", {59'd0, waddr_o}, 64'd0);
    chk("arst_flags", {60'd0, stall_o, busy_o, valid_o, we_o}, 64'd0);
    @(negedge clk);
    rst = 0;
    vcount = 0;
    repeat (40) begin @(negedge clk); vcount += int'(valid_o); end
    chk("arst_novalid", 64'(vcount), 64'd0);
    run(3'b011, 32'hFFFF_FFFF, 32'd2, 5'd23, 32'd1, 33, 0);
    run64(3'b000, 64'h0123_4567_89AB_CDEF, 64'hFFFF_FFFF_FFFF_FFFD);
    run64(3'b001, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000);
    run64(3'b010, 64'hFFFF_FFFF_FFFF_FFF0, 64'h1234_5678_9ABC_DEF0);
    run64(3'b011, 64'hFEDC_BA98_7654_3210, 64'hFFFF_FFFF_0000_0001);
    run64(3'b100, 64'hFFFF_FFFF_FFFF_FF85, 64'd7);
    run64(3'b101, 64'hFFFF_FFFF_FFFF_FF85, 64'd7);
    run64(3'b110, 64'hFFFF_FFFF_FFFF_FF85, 64'd7);
    run64(3'b111, 64'hFFFF_FFFF_FFFF_FF85, 64'd7);
    run64(3'b100, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF);
    run64(3'b110, 64'd5, 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
